// File: rtl/uart_pkg.sv
// Shared UART definitions: baud select codes, divisor mapping, FSM encoding and frame size.
// Used by both the byte transmitter and the byte receiver.
package uart_pkg;

    localparam int CNT_W      = 13;
    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    typedef enum logic [2:0] {
        BAUD_9600   = 3'd0,
        BAUD_19200  = 3'd1,
        BAUD_38400  = 3'd2,
        BAUD_57600  = 3'd3,
        BAUD_115200 = 3'd4
    } baud_code_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Each branch divides two constants, so no divider hardware is built.
    function automatic logic [CNT_W-1:0] baud_div(input logic [2:0] baud_set, input int clk_freq);
        logic [CNT_W-1:0] d;
        case (baud_set)
            BAUD_19200:  d = CNT_W'(clk_freq / 19200);
            BAUD_38400:  d = CNT_W'(clk_freq / 38400);
            BAUD_57600:  d = CNT_W'(clk_freq / 57600);
            BAUD_115200: d = CNT_W'(clk_freq / 115200);
            default:     d = CNT_W'(clk_freq / 9600);
        endcase
        return d;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..div-1 and pulses bit_tick on the wrap cycle.
// clr holds the counter at zero so a new frame starts on a full bit period.
module uart_baud_gen
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] div,
    output logic             bit_tick
);

    logic [CNT_W-1:0] cnt;

    assign bit_tick = !clr && (cnt == div - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || bit_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// 8N1 UART byte transmitter. Outputs are registered from next-state values, so the
// start bit, busy flag and done pulse all appear on the cycle after the deciding edge.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send_en,
    input  logic [2:0] baud_set,
    input  logic [7:0] data_byte,
    output logic       rs232_tx,
    output logic       tx_done,
    output logic       uart_state
);

    tx_state_t        state, state_d;
    logic [2:0]       idx, idx_d, idx_inc;
    logic [7:0]       data_q;
    logic [CNT_W-1:0] div_q;
    logic             tx_d, done_d, busy_d, load, clr, bit_tick;

    assign idx_inc = idx + 3'd1;

    uart_baud_gen u_baud_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .div      (div_q),
        .bit_tick (bit_tick)
    );

    always_comb begin
        state_d = state;
        idx_d   = idx;
        tx_d    = 1'b1;
        done_d  = 1'b0;
        busy_d  = 1'b1;
        load    = 1'b0;
        clr     = 1'b0;
        case (state)
            ST_IDLE: begin
                clr    = 1'b1;
                busy_d = 1'b0;
                if (send_en) begin
                    load    = 1'b1;
                    state_d = ST_START;
                    idx_d   = 3'd0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (bit_tick) begin
                    state_d = ST_DATA;
                    tx_d    = data_q[0];
                end
            end
            ST_DATA: begin
                tx_d = data_q[idx];
                if (bit_tick) begin
                    if (idx == 3'(DATA_BITS - 1)) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d = idx_inc;
                        tx_d  = data_q[idx_inc];
                    end
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= 3'd0;
            data_q     <= 8'd0;
            div_q      <= '0;
            rs232_tx   <= 1'b1;
            tx_done    <= 1'b0;
            uart_state <= 1'b0;
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            rs232_tx   <= tx_d;
            tx_done    <= done_d;
            uart_state <= busy_d;
            if (load) begin
                data_q <= data_byte;
                div_q  <= baud_div(baud_set, CLK_FREQ);
            end
        end
    end

endmodule
